dmem_access_unit: RTL and testbench

Load/store unit between the Riscv151 memory stage and the synchronous data memory. It turns byte-addressed RV32I load/store requests into word-wide, byte-enabled DMEM accesses and sign- or zero-extends returned load data. Misaligned halfword/word accesses are split into two consecutive word accesses, stalling the requester for one extra cycle. Its results are what the assembly bench checks in the register file and DMEM array.

---
 rtl/riscv151_mem_pkg.sv | 44 ++++
 rtl/dmem_lane_align.sv | 45 ++++
 rtl/dmem_access_unit.sv | 124 ++++++++++++
 tb/tb_dmem_access_unit.sv | 266 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/riscv151_mem_pkg.sv
// Shared definitions for the Riscv151 data-memory path: funct3 codes, access
// sizes, load/store unit states and small decode helpers.
package riscv151_mem_pkg;

    localparam logic [2:0] F3_LB  = 3'b000;
    localparam logic [2:0] F3_LH  = 3'b001;
    localparam logic [2:0] F3_LW  = 3'b010;
    localparam logic [2:0] F3_LBU = 3'b100;
    localparam logic [2:0] F3_LHU = 3'b101;

    typedef enum logic [1:0] {
        SIZE_B = 2'b00,
        SIZE_H = 2'b01,
        SIZE_W = 2'b10
    } size_e;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_SPLIT = 1'b1
    } state_e;

    function automatic logic [3:0] size_mask(input logic [1:0] size);
        case (size)
            SIZE_B:  return 4'b0001;
            SIZE_H:  return 4'b0011;
            default: return 4'b1111;
        endcase
    endfunction

    // Unsigned loads have no store counterpart.
    function automatic logic f3_legal(input logic we, input logic [2:0] f3);
        case (f3)
            F3_LB, F3_LH, F3_LW: return 1'b1;
            F3_LBU, F3_LHU:      return ~we;
            default:             return 1'b0;
        endcase
    endfunction

    function automatic logic misaligned(input logic [2:0] f3, input logic [1:0] off);
        return ((f3[1:0] == SIZE_H) && (off == 2'd3)) ||
               ((f3[1:0] == SIZE_W) && (off != 2'd0));
    endfunction

endpackage

// File: rtl/dmem_lane_align.sv
// Combinational byte-lane steering: store enables/data for either half of an
// access, and load extraction plus sign/zero extension from a two-word window.
module dmem_lane_align
    import riscv151_mem_pkg::*;
(
    input  logic [1:0]  st_size,
    input  logic [1:0]  st_off,
    input  logic        st_second,
    input  logic [31:0] st_wdata,
    output logic [3:0]  st_we,
    output logic [31:0] st_lane_wdata,
    input  logic [2:0]  ld_funct3,
    input  logic [1:0]  ld_off,
    input  logic [31:0] ld_word0,
    input  logic [31:0] ld_word1,
    output logic [31:0] ld_data
);

    logic [7:0]  we_wide;
    logic [63:0] wdata_wide;
    logic [63:0] rdata_wide;
    logic        unused_hi;

    // Shifting across an 8-lane window yields both halves of a split access.
    assign we_wide       = {4'b0000, size_mask(st_size)} << st_off;
    assign wdata_wide    = {32'b0, st_wdata} << {st_off, 3'b000};
    assign st_we         = st_second ? we_wide[7:4] : we_wide[3:0];
    assign st_lane_wdata = st_second ? wdata_wide[63:32] : wdata_wide[31:0];

    assign rdata_wide = {ld_word1, ld_word0} >> {ld_off, 3'b000};
    assign unused_hi  = ^rdata_wide[63:32];

    always_comb begin
        // NOTE: ld_data gets a default before the case so no path leaves it unassigned (no latch).
        ld_data = rdata_wide[31:0];
        case (ld_funct3)
            F3_LB:   ld_data = {{24{rdata_wide[7]}}, rdata_wide[7:0]};
            F3_LH:   ld_data = {{16{rdata_wide[15]}}, rdata_wide[15:0]};
            F3_LBU:  ld_data = {24'b0, rdata_wide[7:0]};
            F3_LHU:  ld_data = {16'b0, rdata_wide[15:0]};
            default: ;
        endcase
    end

endmodule

// File: rtl/dmem_access_unit.sv
// RV32I load/store unit in front of a synchronous word-wide DMEM; splits
// misaligned accesses into two consecutive word accesses.
module dmem_access_unit
    import riscv151_mem_pkg::*;
#(
    parameter int ADDR_WIDTH = 14
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic                  req_we,
    input  logic [2:0]            req_funct3,
    input  logic [31:0]           req_addr,
    input  logic [31:0]           req_wdata,
    output logic                  rsp_valid,
    output logic [31:0]           rsp_rdata,
    output logic                  rsp_fault,
    output logic                  mem_en,
    output logic [3:0]            mem_we,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic [31:0]           mem_wdata,
    input  logic [31:0]           mem_rdata
);

    localparam logic [ADDR_WIDTH-1:0] IDX_ONE = 1;

    state_e                state;
    logic                  r_we;
    logic [2:0]            r_f3;
    logic [1:0]            r_off;
    logic [ADDR_WIDTH-1:0] r_idx;
    logic [31:0]           r_wdata;
    logic [31:0]           held_word;
    logic                  r_split;

    logic        in_split, accept, legal;
    logic [3:0]  st_we;
    logic [31:0] st_lane_wdata, ld_data;
    logic        unused_addr;

    assign in_split    = (state == ST_SPLIT);
    assign req_ready   = (state == ST_IDLE) & ~rst;
    assign accept      = req_valid & req_ready;
    assign legal       = f3_legal(req_we, req_funct3);
    assign unused_addr = ^{req_addr[31:ADDR_WIDTH+2]};

    dmem_lane_align u_align (
        .st_size       (in_split ? r_f3[1:0] : req_funct3[1:0]),
        .st_off        (in_split ? r_off : req_addr[1:0]),
        .st_second     (in_split),
        .st_wdata      (in_split ? r_wdata : req_wdata),
        .st_we         (st_we),
        .st_lane_wdata (st_lane_wdata),
        .ld_funct3     (r_f3),
        .ld_off        (r_off),
        .ld_word0      (r_split ? held_word : mem_rdata),
        .ld_word1      (mem_rdata),
        .ld_data       (ld_data)
    );

    always_comb begin
        mem_en    = 1'b0;
        mem_we    = 4'b0000;
        mem_addr  = req_addr[ADDR_WIDTH+1:2];
        mem_wdata = st_lane_wdata;
        if (in_split) begin
            mem_addr = r_idx + IDX_ONE;
            mem_en   = ~rst;
            mem_we   = (r_we & ~rst) ? st_we : 4'b0000;
        end else if (accept & legal) begin
            mem_en = 1'b1;
            mem_we = req_we ? st_we : 4'b0000;
        end
    end

    // Load data arrives one cycle after the access, so it is steered here from the registered request.
    assign rsp_rdata = (rsp_valid & ~rsp_fault & ~r_we) ? ld_data : 32'b0;

    always_ff @(posedge clk) begin
        // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
        if (rst) begin
            state     <= ST_IDLE;
            rsp_valid <= 1'b0;
            rsp_fault <= 1'b0;
            held_word <= 32'b0;
            r_we      <= 1'b0;
            r_f3      <= 3'b000;
            r_off     <= 2'b00;
            r_idx     <= '0;
            r_wdata   <= 32'b0;
            r_split   <= 1'b0;
        end else begin
            rsp_valid <= 1'b0;
            rsp_fault <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (accept) begin
                        r_we    <= req_we;
                        r_f3    <= req_funct3;
                        r_off   <= req_addr[1:0];
                        r_idx   <= req_addr[ADDR_WIDTH+1:2];
                        r_wdata <= req_wdata;
                        r_split <= 1'b0;
                        if (legal && misaligned(req_funct3, req_addr[1:0])) begin
                            state <= ST_SPLIT;
                        end else begin
                            rsp_valid <= 1'b1;
                            rsp_fault <= ~legal;
                        end
                    end
                end
                ST_SPLIT: begin
                    held_word <= mem_rdata;
                    r_split   <= 1'b1;
                    rsp_valid <= 1'b1;
                    state     <= ST_IDLE;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_dmem_access_unit.sv
// Self-checking bench for dmem_access_unit: directed cases plus random traffic
// against a byte-level memory reference model.
module tb_dmem_access_unit;

    localparam int AW    = 14;
    localparam int DEPTH = 1 << AW;

    logic          clk = 1'b0;
    logic          rst;
    logic          req_valid, req_ready, req_we;
    logic [2:0]    req_funct3;
    logic [31:0]   req_addr, req_wdata;
    logic          rsp_valid, rsp_fault;
    logic [31:0]   rsp_rdata;
    logic          mem_en;
    logic [3:0]    mem_we;
    logic [AW-1:0] mem_addr;
    logic [31:0]   mem_wdata, mem_rdata;

    dmem_access_unit #(.ADDR_WIDTH(AW)) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
        .req_funct3(req_funct3), .req_addr(req_addr), .req_wdata(req_wdata),
        .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_fault(rsp_fault),
        .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
    );

    always #5 clk = ~clk;

    // Environment DMEM: synchronous read, byte-enabled write, plus an access log.
    logic [31:0]   dmem [DEPTH];
    logic          mem_init, poke_en;
    logic [AW-1:0] poke_idx;
    logic [31:0]   poke_val;
    int            en_cnt = 0;
    logic [3:0]    we_prev, we_last;
    logic [AW-1:0] addr_prev, addr_last;

    function automatic logic [31:0] seed_word(input int i);
        return (32'(i) * 32'h9E3779B9) ^ 32'h5A5A1234;
    endfunction

    always @(posedge clk) begin
        if (mem_init) begin
            for (int i = 0; i < DEPTH; i++) dmem[i] <= seed_word(i);
        end else if (poke_en) begin
            dmem[poke_idx] <= poke_val;
        end
        if (mem_en) begin
            mem_rdata <= dmem[mem_addr];
            for (int l = 0; l < 4; l++)
                if (mem_we[l]) dmem[mem_addr][8*l +: 8] <= mem_wdata[8*l +: 8];
            en_cnt    <= en_cnt + 1;
            we_prev   <= we_last;
            we_last   <= mem_we;
            addr_prev <= addr_last;
            addr_last <= mem_addr;
        end
    end

    // Reference model: memory as bytes, little-endian, word index wraps.
    logic [31:0] ref_mem [DEPTH];
    int          checks = 0;
    int          errors = 0;
    logic [31:0] last_rdata;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] model_load(input logic [2:0] f3, input logic [31:0] addr);
        logic [31:0] v, ba;
        int n;
        v = 32'b0;
        n = 1 << f3[1:0];
        for (int i = 0; i < n; i++) begin
            ba = addr + 32'(i);
            v[8*i +: 8] = ref_mem[ba[AW+1:2]][8*ba[1:0] +: 8];
        end
        if (f3 == 3'b000) v = {{24{v[7]}}, v[7:0]};
        if (f3 == 3'b001) v = {{16{v[15]}}, v[15:0]};
        return v;
    endfunction

    function automatic void model_store(input logic [2:0] f3, input logic [31:0] addr,
                                        input logic [31:0] wdata, input bit first_only);
        logic [31:0] ba;
        int n;
        n = 1 << f3[1:0];
        for (int i = 0; i < n; i++) begin
            ba = addr + 32'(i);
            if (!(first_only && ba[AW+1:2] != addr[AW+1:2]))
                ref_mem[ba[AW+1:2]][8*ba[1:0] +: 8] = wdata[8*i +: 8];
        end
    endfunction

    task automatic poke(input int idx, input logic [31:0] val);
        poke_en  = 1'b1;
        poke_idx = AW'(idx);
        poke_val = val;
        ref_mem[idx] = val;
        @(negedge clk);
        poke_en = 1'b0;
    endtask

    // Called at a negedge; returns at the negedge of the response cycle.
    task automatic do_req(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                          input logic [31:0] wdata, input string tag);
        bit          legal, mis;
        int          n, exp_lat, exp_acc, lat, en0, widx;
        logic [31:0] exp_data;
        logic        ready_mid;
        n        = 1 << f3[1:0];
        legal    = we ? (f3 < 3'd3) : (f3 inside {3'd0, 3'd1, 3'd2, 3'd4, 3'd5});
        mis      = legal && (n > 1) && (int'(addr[1:0]) + n > 4);
        exp_lat  = mis ? 2 : 1;
        exp_acc  = !legal ? 0 : (mis ? 2 : 1);
        exp_data = (legal && !we) ? model_load(f3, addr) : 32'b0;
        if (legal && we) model_store(f3, addr, wdata, 1'b0);
        req_valid = 1'b1; req_we = we; req_funct3 = f3; req_addr = addr; req_wdata = wdata;
        #1 check({tag, "_ready"}, 32'(req_ready), 32'd1);
        en0 = en_cnt;
        @(negedge clk);
        req_valid = 1'b0;
        ready_mid = req_ready;
        lat = 1;
        while (!rsp_valid && lat < 4) begin
            @(negedge clk);
            lat++;
        end
        check({tag, "_latency"}, 32'(lat), 32'(exp_lat));
        check({tag, "_ready_mid"}, 32'(ready_mid), 32'(!mis));
        check({tag, "_fault"}, 32'(rsp_fault), 32'(!legal));
        check({tag, "_rdata"}, rsp_rdata, exp_data);
        check({tag, "_accesses"}, 32'(en_cnt - en0), 32'(exp_acc));
        last_rdata = rsp_rdata;
        if (legal && we) begin
            widx = int'(addr[AW+1:2]);
            check({tag, "_memW"}, dmem[widx], ref_mem[widx]);
            check({tag, "_memW1"}, dmem[(widx + 1) % DEPTH], ref_mem[(widx + 1) % DEPTH]);
        end
    endtask

    task automatic back_to_back();
        logic [2:0]  f3s [4];
        logic [31:0] addrs [4];
        logic [31:0] exps [4];
        f3s   = '{3'b010, 3'b000, 3'b101, 3'b001};
        addrs = '{32'd0, 32'd5, 32'd10, 32'd12};
        for (int k = 0; k < 4; k++) exps[k] = model_load(f3s[k], addrs[k]);
        for (int k = 0; k < 4; k++) begin
            req_valid = 1'b1; req_we = 1'b0; req_funct3 = f3s[k]; req_addr = addrs[k];
            #1 check($sformatf("b2b%0d_ready", k), 32'(req_ready), 32'd1);
            if (k > 0) begin
                check($sformatf("b2b%0d_valid", k - 1), 32'(rsp_valid), 32'd1);
                check($sformatf("b2b%0d_rdata", k - 1), rsp_rdata, exps[k-1]);
            end
            @(negedge clk);
        end
        req_valid = 1'b0;
        #1 check("b2b3_valid", 32'(rsp_valid), 32'd1);
        check("b2b3_rdata", rsp_rdata, exps[3]);
        @(negedge clk);
    endtask

    initial begin
        logic        we;
        logic [2:0]  f3;
        logic [31:0] addr, idx;
        int          sel, en0;

        rst = 1'b1; mem_init = 1'b1; poke_en = 1'b0; poke_idx = '0; poke_val = 32'b0;
        req_valid = 1'b0; req_we = 1'b0; req_funct3 = 3'b000; req_addr = 32'b0; req_wdata = 32'b0;
        for (int i = 0; i < DEPTH; i++) ref_mem[i] = seed_word(i);
        @(negedge clk);
        mem_init = 1'b0;
        @(negedge clk);
        check("rst_ready", 32'(req_ready), 32'd0);
        check("rst_mem_en", 32'(mem_en), 32'd0);
        check("rst_mem_we", 32'(mem_we), 32'd0);
        check("rst_rsp_valid", 32'(rsp_valid), 32'd0);
        check("rst_rsp_rdata", rsp_rdata, 32'd0);
        check("rst_rsp_fault", 32'(rsp_fault), 32'd0);
        rst = 1'b0;
        @(negedge clk);

        // Directed cases
        poke(0, 32'h8899AABB);
        poke(1, 32'h11223344);
        do_req(1'b0, 3'b000, 32'd1, 32'd0, "lb1");
        check("lb1_value", last_rdata, 32'hFFFFFFAA);
        do_req(1'b0, 3'b100, 32'd1, 32'd0, "lbu1");
        check("lbu1_value", last_rdata, 32'h000000AA);
        do_req(1'b0, 3'b001, 32'd2, 32'd0, "lh2");
        check("lh2_value", last_rdata, 32'hFFFF8899);
        do_req(1'b0, 3'b101, 32'd0, 32'd0, "lhu0");
        check("lhu0_value", last_rdata, 32'h0000AABB);

        poke(8, 32'h11223344);
        do_req(1'b1, 3'b000, 32'd34, 32'hAABBCCDD, "sb");
        check("sb_we", 32'(we_last), 32'b0100);
        check("sb_word", dmem[8], 32'h11DD3344);

        poke(4, 32'd0);
        poke(5, 32'd0);
        do_req(1'b1, 3'b001, 32'd19, 32'h00003344, "sh3");
        check("sh3_we1", 32'(we_prev), 32'b1000);
        check("sh3_we2", 32'(we_last), 32'b0001);
        check("sh3_word4", dmem[4], 32'h44000000);
        check("sh3_word5", dmem[5], 32'h00000033);

        do_req(1'b0, 3'b010, 32'd2, 32'd0, "lw2");
        check("lw2_value", last_rdata, 32'h33448899);

        poke(DEPTH - 1, 32'h8899AABB);
        poke(0, 32'h11223344);
        do_req(1'b0, 3'b010, 32'((DEPTH - 1) * 4 + 2), 32'd0, "lw_wrap");
        check("lw_wrap_value", last_rdata, 32'h33448899);
        check("lw_wrap_addr1", 32'(addr_prev), 32'(DEPTH - 1));
        check("lw_wrap_addr2", 32'(addr_last), 32'd0);

        do_req(1'b0, 3'b011, 32'd4, 32'd0, "f3_011");
        do_req(1'b1, 3'b100, 32'd8, 32'h12345678, "sb_f3_100");

        back_to_back();

        // Reset while the second half of a split store is pending
        poke(6, 32'h01020304);
        poke(7, 32'h05060708);
        req_valid = 1'b1; req_we = 1'b1; req_funct3 = 3'b010; req_addr = 32'd25; req_wdata = 32'hCAFEF00D;
        model_store(3'b010, 32'd25, 32'hCAFEF00D, 1'b1);
        en0 = en_cnt;
        @(negedge clk);
        req_valid = 1'b0;
        rst = 1'b1;
        #1 check("rst_split_mem_en", 32'(mem_en), 32'd0);
        check("rst_split_ready", 32'(req_ready), 32'd0);
        @(negedge clk);
        check("rst_split_rsp_valid", 32'(rsp_valid), 32'd0);
        check("rst_split_accesses", 32'(en_cnt - en0), 32'd1);
        check("rst_split_word6", dmem[6], ref_mem[6]);
        check("rst_split_word7", dmem[7], ref_mem[7]);
        rst = 1'b0;
        @(negedge clk);
        do_req(1'b0, 3'b010, 32'd24, 32'd0, "after_rst");

        // Random traffic over a few words near both ends of memory
        for (int t = 0; t < 400; t++) begin
            sel  = $urandom_range(0, 7);
            idx  = (sel < 6) ? 32'(sel) : 32'(DEPTH - 8 + sel);
            addr = ($urandom & 32'hFFFF0000) | (idx << 2) | 32'($urandom_range(0, 3));
            we   = 1'($urandom_range(0, 1));
            f3   = 3'($urandom_range(0, 7));
            do_req(we, f3, addr, $urandom, $sformatf("rnd%0d", t));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
